regfile_param: RTL
==================

Name: regfile_param

Overview:
Parametrised successor to the single-cycle KGP RISC register file. Provides two asynchronous read ports, one synchronous write port, optional same-cycle write-to-read bypass, an optional hard-wired zero register, and a per-register busy scoreboard for the pipelined core's hazard/stall logic. Sits between decode (reads, issue marking) and writeback (writes, scoreboard clear).

Parameters:
DATA_W, 32, width of each register and of the data ports
ADDR_W, 5, register index width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and marks; 0 = register 0 is ordinary
BYPASS, 1, 1 = read ports forward same-cycle write data and busy clears; 0 = reads see registered state only

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
write_data  input  DATA_W  writeback data
write_reg  input  ADDR_W  writeback register index
regwrite  input  1  write enable; also clears busy[write_reg]
read_reg1  input  ADDR_W  read port 1 index
read_reg2  input  ADDR_W  read port 2 index
read_data1  output  DATA_W  read port 1 data (combinational)
read_data2  output  DATA_W  read port 2 data (combinational)
mark_en  input  1  issue strobe: set busy[mark_reg]
mark_reg  input  ADDR_W  destination index of issued instruction
busy1  output  1  busy state of read_reg1 (combinational)
busy2  output  1  busy state of read_reg2 (combinational)
busy_count  output  ADDR_W+1  number of registers currently busy (registered)

Behaviour:
- Reset (rst=1 at posedge): all registers <= 0, all busy bits <= 0, busy_count <= 0. rst has priority over regwrite and mark_en in the same cycle. Reset mid-operation discards all pending marks.
- After reset: read_data* = 0 and busy* = 0 for every index.
- Write: at posedge with regwrite=1, reg[write_reg] <= write_data. Latency 1 cycle to stored state.
- Read: read_dataN = reg[read_regN], combinational, zero cycles.
- Bypass (BYPASS=1): if regwrite=1 and write_reg==read_regN (and not the zero register), read_dataN = write_data in the same cycle, and busyN = 0 unless mark_en=1 and mark_reg==read_regN in the same cycle. BYPASS=0: old value and old busy until the edge.
- Zero register (ZERO_REG=1): index 0 always reads 0 and busy 0; regwrite and mark_en to index 0 have no effect, bypass never applies, busy_count unaffected.
- Scoreboard update per posedge, per index i:
  - mark_en and mark_reg==i, no clear: busy[i] <= 1.
  - regwrite and write_reg==i, no mark: busy[i] <= 0 (write still performed).
  - Both target i in the same cycle: busy[i] <= 1 (new producer wins); data is still written.
  - Marking an already-busy register: stays 1, no count change.
  - Clearing a non-busy register: stays 0, no count change.
- busy_count: registered population count of busy bits, kept incrementally.
  - Change per cycle in {-1, 0, +1}: +1 on set of 0->1, -1 on clear of 1->0.
  - Both on different indices: net 0.
  - Never exceeds 2**ADDR_W - ZERO_REG and never underflows.
- Both read ports may address the same index; results are identical. No illegal index exists (full decode).

Test Plan:
- Reset: preload reg12=35, assert rst 1 cycle -> read_data1(12)=0, busy_count=0, busy1=0.
- Write/read: regwrite, write_reg=12, write_data=35; read_reg1=12, read_reg2=1 -> same cycle read_data1=35 (BYPASS=1) or 0 until the edge (BYPASS=0); after the edge read_data1=35, read_data2=0.
- Zero register: regwrite reg0=0xDEADBEEF plus mark_en reg0 -> read_data1(0)=0, busy1=0, busy_count=0 (ZERO_REG=1); with ZERO_REG=0 -> 0xDEADBEEF, busy_count=1.
- Scoreboard: mark reg8 at cycle 1 -> busy1(8)=1, busy_count=1; regwrite reg8=9 at cycle 3 -> same cycle busy1=0, read_data1=9; busy_count=0 after the edge.
- Simultaneous events: mark reg5 and regwrite reg5=7 in one cycle -> busy(5)=1, reg5=7; next cycle mark reg6 and clear reg5 -> busy_count stays 1.
- Count saturation: mark all 31 non-zero registers -> busy_count=31; re-mark reg3 -> 31; rst in next cycle while regwrite=1 -> busy_count=0, written reg=0.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with two asynchronous read ports,
// one synchronous write port, optional write-to-read bypass, optional
// hard-wired zero register and a per-register busy scoreboard.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   write_data/write_reg     writeback data and index
//   regwrite                 write enable; also clears busy[write_reg]
//   read_reg1/read_reg2      read indices
//   read_data1/read_data2    read data (combinational)
//   mark_en/mark_reg         issue strobe; sets busy[mark_reg]
//   busy1/busy2              busy state of the read indices (combinational)
//   busy_count               registered number of busy registers
module regfile_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_reg,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busy_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [CNT_W-1:0]  busy_count_q;
    logic [CNT_W-1:0]  busy_count_d;

    // Requests that actually take effect (index 0 is inert when hard-wired)
    logic write_eff;
    logic mark_eff;
    logic cnt_inc;
    logic cnt_dec;

    // Qualify write and mark against the zero register
    always_comb begin
        write_eff = regwrite;
        mark_eff  = mark_en;
        if (ZERO_REG != 0) begin
            if (write_reg == '0) begin
                write_eff = 1'b0;
            end
            if (mark_reg == '0) begin
                mark_eff = 1'b0;
            end
        end
    end

    // Register array next state
    always_comb begin
        regs_d = regs_q;
        if (write_eff) begin
            regs_d[write_reg] = write_data;
        end
    end

    // Scoreboard next state; a mark to the same index overrides the clear
    always_comb begin
        busy_d = busy_q;
        if (write_eff) begin
            busy_d[write_reg] = 1'b0;
        end
        if (mark_eff) begin
            busy_d[mark_reg] = 1'b1;
        end
    end

    // Incremental population count: only real 0->1 and 1->0 transitions count
    always_comb begin
        cnt_inc = mark_eff && !busy_q[mark_reg];
        cnt_dec = write_eff && busy_q[write_reg] &&
                  !(mark_eff && (mark_reg == write_reg));
        busy_count_d = busy_count_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    // Read port 1: stored value, bypassed write, zero register
    always_comb begin
        read_data1 = regs_q[read_reg1];
        busy1      = busy_q[read_reg1];
        if ((BYPASS != 0) && write_eff && (write_reg == read_reg1)) begin
            read_data1 = write_data;
            busy1      = mark_eff && (mark_reg == read_reg1);
        end
        if ((ZERO_REG != 0) && (read_reg1 == '0)) begin
            read_data1 = '0;
            busy1      = 1'b0;
        end
    end

    // Read port 2: identical to port 1
    always_comb begin
        read_data2 = regs_q[read_reg2];
        busy2      = busy_q[read_reg2];
        if ((BYPASS != 0) && write_eff && (write_reg == read_reg2)) begin
            read_data2 = write_data;
            busy2      = mark_eff && (mark_reg == read_reg2);
        end
        if ((ZERO_REG != 0) && (read_reg2 == '0)) begin
            read_data2 = '0;
            busy2      = 1'b0;
        end
    end

    assign busy_count = busy_count_q;

endmodule
